// File: rtl/id_pkg.sv
// Shared decode constants, ALUOp encodings and the control bundle for the ID stage.
package id_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [1:0] {
    AluOpAdd    = 2'b00,
    AluOpBranch = 2'b01,
    AluOpFunct  = 2'b10
  } aluop_e;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   alusrc;
    aluop_e aluop;
    logic   branch;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [6:0] opcode, input logic [2:0] funct3);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        c.aluop    = AluOpFunct;
      end
      OP_LOAD: begin
        c.alusrc   = 1'b1;
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      OP_STORE: begin
        c.alusrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      OP_BRANCH: begin
        // Only beq/bne are branches; other funct3 values fall through as no-ops.
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          c.branch = 1'b1;
          c.aluop  = AluOpBranch;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: x0 hard-wired to zero, write-through bypass on both read ports.
module id_regfile #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  localparam int unsigned RW   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [RW-1:0]   raddr1_i,
  input  logic [RW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [RW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (we_i && raddr1_i == waddr_i) rdata1_o = wdata_i;
    if (we_i && raddr2_i == waddr_i) rdata2_o = wdata_i;
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: control decode, register read, hazard stall, branch resolution, ID/EX register.
// Define ID_BRANCH_FWD_EN to build the MEM->ID branch operand forwarding path.
module id_stage
  import id_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNTW  = 16,
  localparam int unsigned RW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst_id,
  input  logic [XLEN-1:0] pc_id,
  input  logic            valid_id,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [RW-1:0]   ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic [RW-1:0]   mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic [XLEN-1:0] mem_result,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_branch,
  output logic            pc_hold,
  output logic            ifid_hold,
  output logic            ifid_flush,
  output logic            idex_valid,
  output logic            idex_regwrite,
  output logic            idex_memread,
  output logic            idex_memwrite,
  output logic            idex_memtoreg,
  output logic            idex_alusrc,
  output logic [1:0]      idex_aluop,
  output logic [RW-1:0]   idex_rs1,
  output logic [RW-1:0]   idex_rs2,
  output logic [RW-1:0]   idex_rd,
  output logic [XLEN-1:0] idex_rdata1,
  output logic [XLEN-1:0] idex_rdata2,
  output logic [XLEN-1:0] idex_imm,
  output logic [CNTW-1:0] stall_cnt
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [RW-1:0]   rs1, rs2, rd;
  ctrl_t           ctrl;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm;
  logic [XLEN-1:0] rdata1, rdata2, op1, op2;
  logic            ex_hit, mem_hit, stall_lu, stall_br_ex, stall_br_mem, stall;
  logic            issue, br_taken;

  assign opcode = inst_id[6:0];
  assign funct3 = inst_id[14:12];
  assign rd     = inst_id[7 +: RW];
  assign rs1    = inst_id[15 +: RW];
  assign rs2    = inst_id[20 +: RW];
  assign ctrl   = decode(opcode, funct3);

  assign imm_i = {{(XLEN-12){inst_id[31]}}, inst_id[31:20]};
  assign imm_s = {{(XLEN-12){inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
  assign imm_b = {{(XLEN-13){inst_id[31]}}, inst_id[31], inst_id[7], inst_id[30:25],
                  inst_id[11:8], 1'b0};

  always_comb begin
    case (opcode)
      OP_LOAD:   imm = imm_i;
      OP_STORE:  imm = imm_s;
      OP_BRANCH: imm = imm_b;
      default:   imm = '0;
    endcase
  end

  id_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2),
    .we_i     (wb_we),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data)
  );

  assign ex_hit  = (rs1 != '0 && ex_rd == rs1) || (rs2 != '0 && ex_rd == rs2);
  assign mem_hit = (rs1 != '0 && mem_rd == rs1) || (rs2 != '0 && mem_rd == rs2);

  assign stall_lu    = valid_id & ex_memread & ex_hit;
  assign stall_br_ex = valid_id & ctrl.branch & ex_regwrite & ex_hit;

`ifdef ID_BRANCH_FWD_EN
  // A MEM-stage ALU result can feed the comparator; a MEM-stage load cannot.
  assign stall_br_mem = valid_id & ctrl.branch & mem_memread & mem_hit;
  assign op1 = (mem_regwrite && !mem_memread && rs1 != '0 && mem_rd == rs1) ? mem_result : rdata1;
  assign op2 = (mem_regwrite && !mem_memread && rs2 != '0 && mem_rd == rs2) ? mem_result : rdata2;
`else
  logic unused_mem_result;
  assign unused_mem_result = ^mem_result;
  assign stall_br_mem = valid_id & ctrl.branch & (mem_memread | mem_regwrite) & mem_hit;
  assign op1 = rdata1;
  assign op2 = rdata2;
`endif

  assign stall    = stall_lu | stall_br_ex | stall_br_mem;
  assign issue    = valid_id & ~stall;
  assign br_taken = (funct3 == F3_BEQ) ? (op1 == op2) : (op1 != op2);

  assign pc_src     = issue & ctrl.branch & br_taken;
  assign pc_branch  = pc_id + imm_b;
  assign pc_hold    = stall;
  assign ifid_hold  = stall;
  assign ifid_flush = pc_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid    <= 1'b0;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memwrite <= 1'b0;
      idex_memtoreg <= 1'b0;
      idex_alusrc   <= 1'b0;
      idex_aluop    <= 2'b00;
      idex_rs1      <= '0;
      idex_rs2      <= '0;
      idex_rd       <= '0;
      idex_rdata1   <= '0;
      idex_rdata2   <= '0;
      idex_imm      <= '0;
    end else begin
      // Bubble on stall or empty slot: controls cleared, operands still captured.
      idex_valid    <= issue;
      idex_regwrite <= issue & ctrl.regwrite;
      idex_memread  <= issue & ctrl.memread;
      idex_memwrite <= issue & ctrl.memwrite;
      idex_memtoreg <= issue & ctrl.memtoreg;
      idex_alusrc   <= issue & ctrl.alusrc;
      idex_aluop    <= issue ? ctrl.aluop : AluOpAdd;
      idex_rs1      <= rs1;
      idex_rs2      <= rs2;
      idex_rd       <= rd;
      idex_rdata1   <= rdata1;
      idex_rdata2   <= rdata2;
      idex_imm      <= imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != {CNTW{1'b1}}) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed vector bench for id_stage, plus load-then-branch, saturation and async-reset sequences.
module tb_id_stage;
  localparam int XLEN = 64;
  localparam int RW   = 5;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     inst_id;
  logic [XLEN-1:0] pc_id;
  logic            valid_id;
  logic            wb_we;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [RW-1:0]   ex_rd;
  logic            ex_regwrite, ex_memread;
  logic [RW-1:0]   mem_rd;
  logic            mem_regwrite, mem_memread;
  logic [XLEN-1:0] mem_result;
  logic            pc_src, pc_hold, ifid_hold, ifid_flush;
  logic [XLEN-1:0] pc_branch;
  logic            idex_valid, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg;
  logic            idex_alusrc;
  logic [1:0]      idex_aluop;
  logic [RW-1:0]   idex_rs1, idex_rs2, idex_rd;
  logic [XLEN-1:0] idex_rdata1, idex_rdata2, idex_imm;
  logic [CNTW-1:0] stall_cnt;

  id_stage #(.XLEN(XLEN), .NREGS(32), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .pc_id(pc_id), .valid_id(valid_id),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_result(mem_result),
    .pc_src(pc_src), .pc_branch(pc_branch), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .ifid_flush(ifid_flush), .idex_valid(idex_valid), .idex_regwrite(idex_regwrite),
    .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
    .idex_memtoreg(idex_memtoreg), .idex_alusrc(idex_alusrc), .idex_aluop(idex_aluop),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2), .idex_imm(idex_imm),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst; logic [63:0] pc; logic valid;
    logic [4:0] ex_rd; logic ex_rw, ex_mr;
    logic [4:0] mem_rd; logic mem_rw, mem_mr; logic [63:0] mem_res;
    logic wb_we; logic [4:0] wb_rd; logic [63:0] wb_data;
  } in_t;

  // e_ctrl = {regwrite, memread, memwrite, memtoreg, alusrc, aluop[1:0]}
  typedef struct {
    logic stall, src, chkbr; logic [63:0] br;
    logic valid; logic [6:0] ctrl; logic chkd; logic [63:0] rd1, rd2, imm;
  } exp_t;

  typedef struct { in_t i; exp_t e; } vec_t;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rtype(input int rd, input int rs1, input int rs2);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] ld(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b011, rd[4:0], 7'b0000011};
  endfunction
  function automatic logic [31:0] sd(input int rs2, input int rs1, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b011, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] br(input int f3, input int rs1, input int rs2, input int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic in_t inp(input logic [31:0] inst, input logic [63:0] pc, input logic valid,
                              input logic [4:0] exrd, input logic exrw, input logic exmr,
                              input logic [4:0] mrd, input logic mrw, input logic mmr,
                              input logic [63:0] mres, input logic wwe, input logic [4:0] wrd,
                              input logic [63:0] wdat);
    in_t r;
    r.inst = inst; r.pc = pc; r.valid = valid;
    r.ex_rd = exrd; r.ex_rw = exrw; r.ex_mr = exmr;
    r.mem_rd = mrd; r.mem_rw = mrw; r.mem_mr = mmr; r.mem_res = mres;
    r.wb_we = wwe; r.wb_rd = wrd; r.wb_data = wdat;
    return r;
  endfunction

  function automatic exp_t ex(input logic stall, input logic src, input logic chkbr,
                              input logic [63:0] brt, input logic valid, input logic [6:0] ctrl,
                              input logic chkd, input logic [63:0] rd1, input logic [63:0] rd2,
                              input logic [63:0] imm);
    exp_t r;
    r.stall = stall; r.src = src; r.chkbr = chkbr; r.br = brt; r.valid = valid; r.ctrl = ctrl;
    r.chkd = chkd; r.rd1 = rd1; r.rd2 = rd2; r.imm = imm;
    return r;
  endfunction

  task automatic drive(input in_t v);
    inst_id = v.inst; pc_id = v.pc; valid_id = v.valid;
    ex_rd = v.ex_rd; ex_regwrite = v.ex_rw; ex_memread = v.ex_mr;
    mem_rd = v.mem_rd; mem_regwrite = v.mem_rw; mem_memread = v.mem_mr; mem_result = v.mem_res;
    wb_we = v.wb_we; wb_rd = v.wb_rd; wb_data = v.wb_data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_stall();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [63:0] data);
    drive(inp(32'h0, 64'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 64'h0, 1'b1, rd, data));
    step();
  endtask

  localparam logic [6:0] CR  = 7'b1000010;
  localparam logic [6:0] CLD = 7'b1101100;
  localparam logic [6:0] CSD = 7'b0010100;
  localparam logic [6:0] CBR = 7'b0000001;
  localparam logic [63:0] Z  = 64'h0;

  vec_t t[19];

  initial begin
    t[0]  = '{inp(rtype(6, 5, 7), Z, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 0, 0, Z, 1, CR, 1, 64'd7, Z, Z)};
    t[1]  = '{inp(rtype(6, 5, 7), Z, 1, 5'd5, 0, 1, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(1, 0, 0, Z, 0, 7'b0, 0, Z, Z, Z)};
    t[2]  = '{inp(br(0, 3, 4, 16), 64'h100, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 1, 1, 64'h110, 1, CBR, 1, 64'd42, 64'd42, 64'd16)};
    t[3]  = '{inp(br(1, 3, 4, 16), 64'h100, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 0, 1, 64'h110, 1, CBR, 1, 64'd42, 64'd42, 64'd16)};
    t[4]  = '{inp(br(0, 3, 5, -8), 64'h200, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 0, 1, 64'h1F8, 1, CBR, 1, 64'd42, 64'd7, 64'hFFFF_FFFF_FFFF_FFF8)};
    t[5]  = '{inp(br(1, 3, 5, -8), 64'h200, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 1, 1, 64'h1F8, 1, CBR, 1, 64'd42, 64'd7, 64'hFFFF_FFFF_FFFF_FFF8)};
`ifdef ID_BRANCH_FWD_EN
    t[6]  = '{inp(br(0, 3, 5, 8), 64'h40, 1, 5'd0, 0, 0, 5'd5, 1, 0, 64'd42, 0, 5'd0, Z),
              ex(0, 1, 1, 64'h48, 1, CBR, 1, 64'd42, 64'd7, 64'd8)};
`else
    t[6]  = '{inp(br(0, 3, 5, 8), 64'h40, 1, 5'd0, 0, 0, 5'd5, 1, 0, 64'd42, 0, 5'd0, Z),
              ex(1, 0, 1, 64'h48, 0, 7'b0, 0, Z, Z, Z)};
`endif
    t[7]  = '{inp(br(0, 3, 4, 16), 64'h100, 1, 5'd4, 1, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(1, 0, 1, 64'h110, 0, 7'b0, 0, Z, Z, Z)};
    t[8]  = '{inp(rtype(6, 4, 3), Z, 1, 5'd4, 1, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 0, 0, Z, 1, CR, 1, 64'd42, 64'd42, Z)};
    t[9]  = '{inp(rtype(6, 5, 7), Z, 0, 5'd5, 0, 1, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 0, 0, Z, 0, 7'b0, 0, Z, Z, Z)};
    t[10] = '{inp(ld(8, 10, 24), Z, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 0, 0, Z, 1, CLD, 1, 64'd5, Z, 64'd24)};
    t[11] = '{inp(sd(4, 3, -16), Z, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 0, 0, Z, 1, CSD, 1, 64'd42, 64'd42, 64'hFFFF_FFFF_FFFF_FFF0)};
    t[12] = '{inp(32'h0, Z, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 0, 0, Z, 1, 7'b0, 0, Z, Z, Z)};
    t[13] = '{inp(br(4, 3, 4, 16), 64'h100, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 0, 0, Z, 1, 7'b0, 0, Z, Z, Z)};
    t[14] = '{inp(rtype(6, 0, 0), Z, 1, 5'd0, 0, 1, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 0, 0, Z, 1, CR, 1, Z, Z, Z)};
    t[15] = '{inp(rtype(1, 9, 0), Z, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 1, 5'd9, 64'hDEAD),
              ex(0, 0, 0, Z, 1, CR, 1, 64'hDEAD, Z, Z)};
    t[16] = '{inp(rtype(1, 0, 0), Z, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 1, 5'd0, 64'hFFFF),
              ex(0, 0, 0, Z, 1, CR, 1, Z, Z, Z)};
    t[17] = '{inp(rtype(1, 9, 0), Z, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z),
              ex(0, 0, 0, Z, 1, CR, 1, 64'hDEAD, Z, Z)};
    t[18] = '{inp(rtype(1, 9, 9), Z, 1, 5'd0, 0, 0, 5'd9, 0, 1, Z, 0, 5'd0, Z),
              ex(0, 0, 0, Z, 1, CR, 1, 64'hDEAD, 64'hDEAD, Z)};

    rst_n = 1'b0;
    drive(inp(32'h0, Z, 0, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z));
    #12;
    chk("reset idex_valid", idex_valid, 0);
    chk("reset idex_ctrl", {idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg,
                            idex_alusrc, idex_aluop}, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    step();

    wb_write(5'd3, 64'd42);
    wb_write(5'd4, 64'd42);
    wb_write(5'd5, 64'd7);
    wb_write(5'd10, 64'd5);

    for (int k = 0; k < 19; k++) begin
      drive(t[k].i);
      #1;
      chk($sformatf("v%0d pc_hold", k), pc_hold, t[k].e.stall);
      chk($sformatf("v%0d ifid_hold", k), ifid_hold, t[k].e.stall);
      chk($sformatf("v%0d pc_src", k), pc_src, t[k].e.src);
      chk($sformatf("v%0d ifid_flush", k), ifid_flush, t[k].e.src);
      if (t[k].e.chkbr) chk($sformatf("v%0d pc_branch", k), pc_branch, t[k].e.br);
      step();
      if (t[k].e.stall) count_stall();
      chk($sformatf("v%0d idex_valid", k), idex_valid, t[k].e.valid);
      chk($sformatf("v%0d idex_ctrl", k), {idex_regwrite, idex_memread, idex_memwrite,
                                            idex_memtoreg, idex_alusrc, idex_aluop}, t[k].e.ctrl);
      if (t[k].e.chkd) begin
        chk($sformatf("v%0d idex_rdata1", k), idex_rdata1, t[k].e.rd1);
        chk($sformatf("v%0d idex_rdata2", k), idex_rdata2, t[k].e.rd2);
        chk($sformatf("v%0d idex_imm", k), idex_imm, t[k].e.imm);
      end
      chk($sformatf("v%0d stall_cnt", k), stall_cnt, exp_cnt);
    end

    // bne x8,x0 behind ld x8: load-use stall, then MEM-load stall, then resolves via bypass.
    drive(inp(br(1, 8, 0, 12), 64'h300, 1, 5'd8, 1, 1, 5'd0, 0, 0, Z, 0, 5'd0, Z));
    #1;
    chk("ldbr c1 pc_hold", pc_hold, 1);
    chk("ldbr c1 pc_src", pc_src, 0);
    step(); count_stall();
    drive(inp(br(1, 8, 0, 12), 64'h300, 1, 5'd0, 0, 0, 5'd8, 1, 1, Z, 0, 5'd0, Z));
    #1;
    chk("ldbr c2 pc_hold", pc_hold, 1);
    chk("ldbr c2 pc_src", pc_src, 0);
    step(); count_stall();
    drive(inp(br(1, 8, 0, 12), 64'h300, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 1, 5'd8, 64'd77));
    #1;
    chk("ldbr c3 pc_hold", pc_hold, 0);
    chk("ldbr c3 pc_src", pc_src, 1);
    chk("ldbr c3 pc_branch", pc_branch, 64'h30C);
    step();
    chk("ldbr idex_valid", idex_valid, 1);
    chk("ldbr stall_cnt", stall_cnt, exp_cnt);

    // Held load-use stall for 20 cycles saturates the 4-bit counter.
    drive(inp(rtype(6, 5, 7), Z, 1, 5'd5, 0, 1, 5'd0, 0, 0, Z, 0, 5'd0, Z));
    for (int c = 0; c < 20; c++) begin
      step();
      count_stall();
    end
    chk("sat stall_cnt model", stall_cnt, exp_cnt);
    chk("sat stall_cnt 15", stall_cnt, 15);

    // Asynchronous reset in the middle of a stall, with a live ld sitting in ID/EX.
    drive(inp(ld(8, 10, 24), Z, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z));
    step();
    drive(inp(rtype(6, 5, 7), Z, 1, 5'd5, 0, 1, 5'd0, 0, 0, Z, 0, 5'd0, Z));
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("arst idex_valid", idex_valid, 0);
    chk("arst idex_ctrl", {idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg,
                           idex_alusrc, idex_aluop}, 0);
    chk("arst idex_rdata1", idex_rdata1, 0);
    chk("arst idex_imm", idex_imm, 0);
    chk("arst stall_cnt", stall_cnt, 0);
    chk("arst pc_hold comb", pc_hold, 1);
    #1;
    rst_n = 1'b1;
    drive(inp(rtype(1, 5, 3), Z, 1, 5'd0, 0, 0, 5'd0, 0, 0, Z, 0, 5'd0, Z));
    step();
    chk("post-reset x5", idex_rdata1, 0);
    chk("post-reset x3", idex_rdata2, 0);
    chk("post-reset idex_rs1", idex_rs1, 5);
    chk("post-reset idex_valid", idex_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised instruction-decode stage for the five-stage RISC-V pipeline, placed between the IF/ID and EX stages. It decodes ld, sd, beq, bne and R-type instructions, holds the architectural register file, and detects load-use and branch-operand hazards. Branches resolve in ID. The stage owns a registered ID/EX bundle, so the EX stage receives clean pipeline-register outputs, and it keeps a saturating stall counter for performance work.

## Interface
Parameters:
- XLEN, 64, datapath and register width
- NREGS, 32, architectural register count; register index width RW = clog2(NREGS)
- CNTW, 16, stall counter width

Ports:
- clk  in  1  clock; every state element updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- inst_id  in  32  instruction from IF/ID
- pc_id  in  XLEN  PC of inst_id
- valid_id  in  1  inst_id holds a real instruction
- wb_we, wb_rd, wb_data  in  1/RW/XLEN  writeback port
- ex_rd, ex_regwrite, ex_memread  in  RW/1/1  destination and controls of the instruction currently in EX
- mem_rd, mem_regwrite, mem_memread, mem_result  in  RW/1/1/XLEN  destination, controls and ALU result of the instruction in MEM
- pc_src  out  1  branch taken, resolved this cycle
- pc_branch  out  XLEN  branch target, pc_id + imm
- pc_hold, ifid_hold  out  1  freeze PC and IF/ID
- ifid_flush  out  1  squash IF/ID; equals pc_src
- idex_valid, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc  out  1 each  registered controls
- idex_aluop  out  2  registered ALUOp
- idex_rs1, idex_rs2, idex_rd  out  RW  registered register indices
- idex_rdata1, idex_rdata2, idex_imm  out  XLEN  registered operands and immediate
- stall_cnt  out  CNTW  saturating count of stall cycles

## Operation
- Decode:
  - R-type (0110011): ALUOp=10, regwrite.
  - ld (0000011): alusrc, memread, memtoreg, regwrite, ALUOp=00.
  - sd (0100011): alusrc, memwrite, ALUOp=00.
  - Branch (1100011), funct3 000=beq, 001=bne: ALUOp=01. Any other funct3 is decoded as a no-op.
  - Unknown opcode: all controls 0.
- Immediates are sign-extended to XLEN. I, S and B formats are supported. The B immediate includes bit 0 = 0, and pc_branch = pc_id + imm_B.
- Register file:
  - NREGS×XLEN, synchronous write on the rising edge.
  - Register 0 is hard-wired to 0; writes to it are ignored.
  - Read bypass: when wb_we is set and wb_rd equals a source index (nonzero), that read returns wb_data in the same cycle.
- The stall condition is the OR of the following terms, each evaluated only when valid_id=1 and the matching source index is nonzero:
  - Load-use: ex_memread and ex_rd ∈ {rs1, rs2}.
  - Branch, EX producer: the ID instruction is a branch, ex_regwrite is set, and ex_rd ∈ {rs1, rs2}.
  - Branch, MEM load: the ID instruction is a branch, mem_memread is set, and mem_rd ∈ {rs1, rs2}.
- On stall:
  - pc_hold=1 and ifid_hold=1.
  - The ID/EX register loads a bubble: all controls 0 and idex_valid=0.
  - pc_src is forced to 0.
- Branch compare operands, per source: use mem_result if mem_regwrite is set, mem_memread is clear and mem_rd matches (nonzero). Otherwise use the register-file/bypass value.
- Branch resolution:
  - pc_src = valid_id & branch & !stall & (beq ? eq : !eq).
  - ifid_flush = pc_src.
  - The branch itself still enters ID/EX, with all write controls 0.
- stall_cnt increments by 1 each stalled cycle and saturates at 2^CNTW−1.

## Timing
- Reset (rst_n low, asynchronous):
  - All idex_* outputs are 0.
  - stall_cnt = 0.
  - All registers are cleared to 0.
- pc_src, pc_branch, pc_hold, ifid_hold and ifid_flush are combinational from the current inputs and have no reset dependence.
- Latency: decode to idex_* takes 1 cycle.
- Stall persists for as long as its condition holds. A branch that depends on an EX load stalls 2 cycles: first as load-use, then as MEM-load.
- Writeback to the same register as a read in the same cycle: the read returns wb_data.
- Stall and branch in the same cycle: stall wins, and the branch is re-evaluated next cycle.
- rst_n asserted mid-stall: outputs clear immediately and stall_cnt=0.

## Configuration
- ID_BRANCH_FWD_EN defined: the MEM→ID branch forwarding described above is built in.
- ID_BRANCH_FWD_EN undefined: no forwarding path. A branch additionally stalls whenever mem_regwrite is set and mem_rd matches a nonzero source. Compare operands come only from the register file/bypass.

## Structure
- Package id_pkg holds:
  - opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH;
  - funct3 constants F3_BEQ, F3_BNE;
  - ALUOp encodings;
  - a packed ctrl_t struct (regwrite, memread, memwrite, memtoreg, alusrc, aluop, branch).
- One sub-module: id_regfile (register file with write bypass, parametrised by XLEN and NREGS).

## Test plan
- Reset: assert rst_n=0 mid-run → every idex_* output and stall_cnt read 0 immediately; x5 reads 0 after release.
- Load-use: EX ld x5 with ID add x6,x5,x7 → pc_hold=1 for 1 cycle, idex_valid=0 next edge, stall_cnt=1.
- beq forward (ID_BRANCH_FWD_EN defined): MEM add writes x3=42, x4=42 in the register file, ID beq x3,x4,+16 at pc 0x100 → pc_src=1, pc_branch=0x110, ifid_flush=1, no stall.
- bne after EX load: ld x8 in EX with ID bne x8,x0 → 2 stall cycles, then resolves taken when the loaded value is nonzero.
- Bypass: wb_we=1, wb_rd=9, wb_data=0xDEAD with rs1=9 in ID → idex_rdata1=0xDEAD next edge. Writing x0 has no effect.
- Saturation: CNTW=4, hold a stall for 20 cycles → stall_cnt holds at 15.
